program_load_sequencer: RTL and testbench
=========================================

// Module: program_load_sequencer
// PURPOSE
//  Hardware sequencer for the CPU program/data memory load port. Accepts a byte
//  stream over a valid/ready handshake and writes the first INST_BYTES bytes at
//  address 0 and up, then DATA_BYTES pixel bytes at DATA_BASE and up.
//  It then releases CPU reset, pulses startProgram and waits for cpu_done.
//  Sits between the host byte source (UART/DMA) and the CPU memory write port.
// PARAMETERS
//  ADDR_W      32      width of programAddress
//  INST_BYTES  202     instruction bytes (written at 0..INST_BYTES-1); must be >=1
//  DATA_BASE   256     first pixel-data address; must be >= INST_BYTES
//  DATA_BYTES  200005  pixel bytes (DATA_BASE..DATA_BASE+DATA_BYTES-1); 0 = skip data phase
// PORTS
//  clk            in   1       system clock, rising edge
//  reset          in   1       synchronous, active-low reset
//  go             in   1       1-cycle pulse: begin a load (honoured in IDLE/DONE only)
//  abort          in   1       return to IDLE from any state; CPU held in reset
//  in_valid       in   1       input byte valid
//  in_byte        in   8       input byte
//  in_ready       out  1       sequencer can accept a byte this cycle
//  programAddress out  ADDR_W  memory write address
//  programByte    out  8       memory write data
//  programWrEn    out  1       memory write strobe, 1 cycle per byte
//  cpu_reset      out  1       active-high CPU reset, held during load
//  startProgram   out  1       1-cycle pulse on entry to RUN
//  cpu_done       in   1       CPU finished (level); sampled in RUN only
//  busy           out  1       1 in LOAD_INST/LOAD_DATA/RUN
//  done           out  1       1 in DONE
// BEHAVIOUR
//  Reset (reset==0 at edge): state=IDLE, in_ready=0, programWrEn=0, programAddress=0,
//   programByte=0, cpu_reset=1, startProgram=0, busy=0, done=0, counters=0.
//  States: IDLE -> LOAD_INST -> LOAD_DATA -> START -> RUN -> DONE.
//  IDLE/DONE: in_ready=0; go -> LOAD_INST with byte_cnt=0, cpu_reset=1, done=0.
//  LOAD_INST/LOAD_DATA: in_ready=1; accept = in_valid & in_ready.
//  Each accept registers one write the next cycle: programWrEn=1, programByte=in_byte.
//   programAddress=byte_cnt in LOAD_INST; DATA_BASE+byte_cnt in LOAD_DATA.
//   No accept -> programWrEn=0 and address/data hold their last value.
//  Accept of byte INST_BYTES-1 -> LOAD_DATA with byte_cnt=0, or START if DATA_BYTES==0.
//  Accept of data byte DATA_BYTES-1 -> START. in_ready is 0 from the following cycle.
//  START (1 cycle, after the final write strobe): cpu_reset=0, startProgram=1 -> RUN.
//   The CPU therefore never leaves reset before the last byte is in memory.
//  RUN: in_ready=0, startProgram=0; cpu_done=1 -> DONE (cpu_reset stays 0).
//  DONE: done=1; go restarts a load and reasserts cpu_reset the same edge.
//  go outside IDLE/DONE: ignored. in_valid outside load states: ignored, nothing written.
//  abort has priority over go and over accept in the same cycle. It goes to IDLE,
//   cpu_reset=1, and the pending byte is not written. A write already registered
//   on that edge still completes.
//  Counters: byte_cnt width = clog2(max(INST_BYTES,DATA_BYTES)+1). Address sum is
//   ADDR_W bits with no wrap; params are sized so DATA_BASE+DATA_BYTES fits ADDR_W.
//  Reset mid-load: immediate IDLE; the partial memory image is left as is.
// STRUCTURE
//  loader_pkg: state encoding (IDLE..DONE) and the default INST_BYTES/DATA_BASE/
//   DATA_BYTES constants shared with the CPU top level and the bench.
//  One sub-module, load_byte_counter: clear/enable/terminal-count flag at a
//   programmable limit. It is reused for both phases.
//  Top: FSM, write-port output registers, handshake logic.
// TESTING  (bench params INST_BYTES=4, DATA_BASE=16, DATA_BYTES=3)
//  1 go, 7 back-to-back bytes 0xA0..0xA6 -> writes (0,A0)..(3,A3),(16,A4)..(18,A6).
//    Then startProgram pulses once the cycle after the write to 18; cpu_reset falls the same cycle.
//  2 in_valid toggling 1/0 each cycle -> exactly 7 programWrEn pulses, addresses
//    contiguous, no duplicated or skipped bytes.
//  3 abort during the 2nd data byte -> IDLE, cpu_reset=1, no write to 17.
//    A following go reloads from address 0.
//  4 cpu_done=1 held before start, then RUN -> DONE after one RUN cycle, done=1.
//    A go pulse while in RUN is ignored.
//  5 DATA_BYTES=0 build: 4 bytes -> START directly, no write at or above 16.
//  6 reset=0 in LOAD_DATA -> next cycle all outputs at reset values, in_ready=0.

Source files
------------

// File: rtl/program_load_sequencer_pkg.sv
// Shared state encoding and default load-image geometry for the program loader,
// its CPU top level and the bench.
package program_load_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_LOAD_INST = 3'd1,
        ST_LOAD_DATA = 3'd2,
        ST_START     = 3'd3,
        ST_RUN       = 3'd4,
        ST_DONE      = 3'd5
    } state_e;

    localparam int DEF_ADDR_W     = 32;
    localparam int DEF_INST_BYTES = 202;
    localparam int DEF_DATA_BASE  = 256;
    localparam int DEF_DATA_BYTES = 200005;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/program_load_sequencer_if.sv
// Byte-stream, memory-write and CPU-control bundle of the program loader.
// slave = the sequencer, master = host byte source plus CPU side.
interface program_load_sequencer_if
    import program_load_sequencer_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W
);
    logic              go;
    logic              abort;
    logic              in_valid;
    logic [7:0]        in_byte;
    logic              in_ready;
    logic [ADDR_W-1:0] programAddress;
    logic [7:0]        programByte;
    logic              programWrEn;
    logic              cpu_reset;
    logic              startProgram;
    logic              cpu_done;
    logic              busy;
    logic              done;

    modport slave (
        input  go, abort, in_valid, in_byte, cpu_done,
        output in_ready, programAddress, programByte, programWrEn,
        output cpu_reset, startProgram, busy, done
    );

    modport master (
        output go, abort, in_valid, in_byte, cpu_done,
        input  in_ready, programAddress, programByte, programWrEn,
        input  cpu_reset, startProgram, busy, done
    );
endinterface

// File: rtl/program_load_sequencer_cnt.sv
// Byte counter with clear/enable and a terminal flag at a runtime limit; one cycle
// per increment, clear wins over enable, no backpressure of its own.
module program_load_sequencer_cnt #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr_i,
    input  logic         en_i,
    input  logic [W-1:0] limit_i,
    output logic [W-1:0] cnt_o,
    output logic         last_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o  = cnt_q;
    assign last_o = (cnt_q == limit_i);

endmodule

// File: rtl/program_load_sequencer.sv
// Loads instruction then pixel bytes into CPU memory, then starts the CPU and waits
// for completion; each accepted byte is written one cycle later, in_ready drops outside load.
module program_load_sequencer
    import program_load_sequencer_pkg::*;
#(
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int INST_BYTES = DEF_INST_BYTES,
    parameter int DATA_BASE  = DEF_DATA_BASE,
    parameter int DATA_BYTES = DEF_DATA_BYTES
) (
    input  logic clk,
    input  logic reset,
    program_load_sequencer_if.slave bus
);

    localparam int CNT_W = $clog2(max_int(INST_BYTES, DATA_BYTES) + 1);
    localparam logic [CNT_W-1:0]  INST_LIM = CNT_W'(INST_BYTES - 1);
    localparam logic [CNT_W-1:0]  DATA_LIM = CNT_W'((DATA_BYTES == 0) ? 0 : DATA_BYTES - 1);
    localparam logic [ADDR_W-1:0] BASE_A   = ADDR_W'(DATA_BASE);

    state_e state_q;
    state_e state_d;

    logic              in_ready_q, in_ready_d;
    logic              wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        byte_q, byte_d;
    logic              cpu_reset_q, cpu_reset_d;
    logic              start_q, start_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic             load_st;
    logic             idle_st;
    logic             wr;
    logic             cnt_clr;
    logic             cnt_last;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_lim;

    assign load_st = (state_q == ST_LOAD_INST) || (state_q == ST_LOAD_DATA);
    assign idle_st = (state_q == ST_IDLE) || (state_q == ST_DONE);

    // abort swallows the byte presented in the same cycle
    assign wr      = bus.in_valid & in_ready_q & load_st & ~bus.abort;
    assign cnt_lim = (state_q == ST_LOAD_DATA) ? DATA_LIM : INST_LIM;
    assign cnt_clr = bus.abort | (wr & cnt_last) | (idle_st & bus.go);

    program_load_sequencer_cnt #(
        .W (CNT_W)
    ) u_cnt (
        .clk     (clk),
        .reset   (reset),
        .clr_i   (cnt_clr),
        .en_i    (wr),
        .limit_i (cnt_lim),
        .cnt_o   (cnt),
        .last_o  (cnt_last)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (bus.abort) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (bus.go) state_d = ST_LOAD_INST;
                end
                ST_LOAD_INST: begin
                    if (wr && cnt_last) state_d = (DATA_BYTES == 0) ? ST_START : ST_LOAD_DATA;
                end
                ST_LOAD_DATA: begin
                    if (wr && cnt_last) state_d = ST_START;
                end
                ST_START: state_d = ST_RUN;
                ST_RUN: begin
                    if (bus.cpu_done) state_d = ST_DONE;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Outputs are registered from the next state, so START (the cycle holding the
    // last write strobe) shows up as startProgram on the first RUN cycle.
    always_comb begin
        wr_en_d = wr;
        addr_d  = addr_q;
        byte_d  = byte_q;
        if (wr) begin
            byte_d = bus.in_byte;
            addr_d = (state_q == ST_LOAD_DATA) ? (BASE_A + ADDR_W'(cnt)) : ADDR_W'(cnt);
        end
        in_ready_d  = (state_d == ST_LOAD_INST) || (state_d == ST_LOAD_DATA);
        busy_d      = in_ready_d || (state_d == ST_RUN);
        done_d      = (state_d == ST_DONE);
        start_d     = (state_q == ST_START) && (state_d == ST_RUN);
        cpu_reset_d = !((state_d == ST_RUN) || (state_d == ST_DONE));
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            in_ready_q  <= 1'b0;
            wr_en_q     <= 1'b0;
            addr_q      <= '0;
            byte_q      <= '0;
            cpu_reset_q <= 1'b1;
            start_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            in_ready_q  <= in_ready_d;
            wr_en_q     <= wr_en_d;
            addr_q      <= addr_d;
            byte_q      <= byte_d;
            cpu_reset_q <= cpu_reset_d;
            start_q     <= start_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign bus.in_ready       = in_ready_q;
    assign bus.programWrEn    = wr_en_q;
    assign bus.programAddress = addr_q;
    assign bus.programByte    = byte_q;
    assign bus.cpu_reset      = cpu_reset_q;
    assign bus.startProgram   = start_q;
    assign bus.busy           = busy_q;
    assign bus.done           = done_q;

endmodule

// File: tb/tb_program_load_sequencer.sv
// Directed bench: 4 instruction bytes, data base 16, 3 data bytes, plus a no-data build.
module tb_program_load_sequencer;

    logic clk;
    logic reset;

    program_load_sequencer_if #(.ADDR_W(32)) bus  ();
    program_load_sequencer_if #(.ADDR_W(32)) bus0 ();

    program_load_sequencer #(
        .ADDR_W(32), .INST_BYTES(4), .DATA_BASE(16), .DATA_BYTES(3)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    program_load_sequencer #(
        .ADDR_W(32), .INST_BYTES(4), .DATA_BASE(16), .DATA_BYTES(0)
    ) dut0 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus0)
    );

    typedef struct {
        logic [31:0] a;
        logic [7:0]  d;
        int          c;
    } wr_t;

    wr_t log0[$];
    wr_t log1[$];
    wr_t w0, w1;
    int  cyc = 0;
    int  st_n = 0, st_cyc = -1;
    int  st1_n = 0;
    int  total = 0, bad = 0;
    int  w_cyc;
    int  exp_a[7] = '{0, 1, 2, 3, 16, 17, 18};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus.programWrEn) begin
            w0.a = bus.programAddress; w0.d = bus.programByte; w0.c = cyc;
            log0.push_back(w0);
        end
        if (bus.startProgram) begin
            st_n++;
            st_cyc = cyc;
        end
        if (bus0.programWrEn) begin
            w1.a = bus0.programAddress; w1.d = bus0.programByte; w1.c = cyc;
            log1.push_back(w1);
        end
        if (bus0.startProgram) st1_n++;
    end

    initial begin
        #100000;
        $display("FAIL watchdog total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_go();
        bus.go = 1'b1;
        tick();
        bus.go = 1'b0;
    endtask

    // Presents bytes b0, b0+1, ... until n are accepted; gap alternates in_valid.
    task automatic send(input int n, input logic [7:0] b0, input bit gap);
        int  sent = 0;
        int  guard = 0;
        bit  v = 1'b1;
        bit  acc;
        while (sent < n && guard < 100) begin
            bus.in_valid = v;
            bus.in_byte  = 8'(b0 + sent);
            acc = v && bus.in_ready;
            tick();
            if (acc) sent++;
            if (gap) v = ~v;
            guard++;
        end
        bus.in_valid = 1'b0;
        chk("send_cnt", sent, n);
    endtask

    function automatic int cnt_addr(input logic [31:0] a);
        int k = 0;
        foreach (log0[i]) if (log0[i].a == a) k++;
        return k;
    endfunction

    task automatic check_log(input string tag, input logic [7:0] b0);
        chk({tag, "_nwr"}, log0.size(), 7);
        for (int i = 0; i < 7; i++) begin
            if (i < log0.size()) begin
                chk({tag, "_addr"}, log0[i].a, exp_a[i]);
                chk({tag, "_data"}, log0[i].d, 8'(b0 + i));
            end
        end
    endtask

    initial begin
        reset = 1'b0;
        bus.go = 0; bus.abort = 0; bus.in_valid = 0; bus.in_byte = 0; bus.cpu_done = 0;
        bus0.go = 0; bus0.abort = 0; bus0.in_valid = 0; bus0.in_byte = 0; bus0.cpu_done = 0;
        repeat (2) tick();
        chk("rst_rdy",    bus.in_ready, 0);
        chk("rst_wren",   bus.programWrEn, 0);
        chk("rst_addr",   bus.programAddress, 0);
        chk("rst_byte",   bus.programByte, 0);
        chk("rst_cpurst", bus.cpu_reset, 1);
        chk("rst_start",  bus.startProgram, 0);
        chk("rst_busy",   bus.busy, 0);
        chk("rst_done",   bus.done, 0);
        reset = 1'b1;
        tick();

        // 1: back-to-back load, start timing, go ignored in RUN
        log0.delete(); st_n = 0;
        pulse_go();
        chk("t1_rdy", bus.in_ready, 1);
        send(7, 8'hA0, 1'b0);
        w_cyc = cyc;
        chk("t1_start_wr", bus.startProgram, 0);
        chk("t1_cpurst_wr", bus.cpu_reset, 1);
        tick();
        chk("t1_start", bus.startProgram, 1);
        chk("t1_cpurst", bus.cpu_reset, 0);
        chk("t1_rdy_off", bus.in_ready, 0);
        tick();
        check_log("t1", 8'hA0);
        chk("t1_last_cyc", (log0.size() > 0) ? log0[log0.size()-1].c : -1, w_cyc);
        chk("t1_st_cyc", st_cyc, w_cyc + 1);
        chk("t1_st_n", st_n, 1);
        pulse_go();
        chk("t1_run_busy", bus.busy, 1);
        chk("t1_run_done", bus.done, 0);
        chk("t1_run_cpurst", bus.cpu_reset, 0);
        chk("t1_run_nwr", log0.size(), 7);
        bus.cpu_done = 1'b1;
        tick();
        bus.cpu_done = 1'b0;
        chk("t1_done", bus.done, 1);
        chk("t1_done_busy", bus.busy, 0);

        // 2: in_valid toggling
        log0.delete(); st_n = 0;
        pulse_go();
        chk("t2_cpurst", bus.cpu_reset, 1);
        chk("t2_done_clr", bus.done, 0);
        send(7, 8'hB0, 1'b1);
        repeat (3) tick();
        check_log("t2", 8'hB0);
        chk("t2_st_n", st_n, 1);
        bus.cpu_done = 1'b1;
        tick();
        bus.cpu_done = 1'b0;
        chk("t2_done", bus.done, 1);

        // 3: abort on the second data byte, then reload from 0
        log0.delete();
        pulse_go();
        send(5, 8'hA0, 1'b0);
        bus.in_valid = 1'b1; bus.in_byte = 8'hA5; bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0; bus.in_valid = 1'b0;
        chk("t3_rdy", bus.in_ready, 0);
        chk("t3_cpurst", bus.cpu_reset, 1);
        chk("t3_busy", bus.busy, 0);
        repeat (2) tick();
        chk("t3_nwr", log0.size(), 5);
        chk("t3_no17", cnt_addr(32'd17), 0);
        log0.delete();
        pulse_go();
        send(1, 8'hD0, 1'b0);
        chk("t3_re_wren", bus.programWrEn, 1);
        chk("t3_re_addr", bus.programAddress, 0);
        chk("t3_re_byte", bus.programByte, 8'hD0);

        // 4: cpu_done already high before start
        st_n = 0;
        bus.cpu_done = 1'b1;
        send(6, 8'hD1, 1'b0);
        chk("t4_cpurst_wr", bus.cpu_reset, 1);
        chk("t4_done_wr", bus.done, 0);
        tick();
        chk("t4_start", bus.startProgram, 1);
        chk("t4_run_busy", bus.busy, 1);
        chk("t4_run_done", bus.done, 0);
        tick();
        bus.cpu_done = 1'b0;
        chk("t4_done", bus.done, 1);
        chk("t4_busy", bus.busy, 0);
        chk("t4_cpurst", bus.cpu_reset, 0);
        chk("t4_start_off", bus.startProgram, 0);
        chk("t4_st_n", st_n, 1);
        chk("t4_nwr", log0.size(), 7);
        chk("t4_w18", cnt_addr(32'd18), 1);

        // 5: no-data build goes straight to START
        bus0.go = 1'b1;
        tick();
        bus0.go = 1'b0;
        chk("t5_rdy", bus0.in_ready, 1);
        for (int i = 0; i < 4; i++) begin
            bus0.in_valid = 1'b1;
            bus0.in_byte  = 8'(8'hC0 + i);
            tick();
        end
        bus0.in_valid = 1'b0;
        chk("t5_wr_addr", bus0.programAddress, 3);
        chk("t5_wr_byte", bus0.programByte, 8'hC3);
        chk("t5_rdy_off", bus0.in_ready, 0);
        tick();
        chk("t5_start", bus0.startProgram, 1);
        chk("t5_cpurst", bus0.cpu_reset, 0);
        repeat (2) tick();
        chk("t5_nwr", log1.size(), 4);
        for (int i = 0; i < 4; i++) begin
            if (i < log1.size()) chk("t5_addr", log1[i].a, i);
        end
        chk("t5_st_n", st1_n, 1);

        // 6: reset in the data phase
        log0.delete();
        pulse_go();
        send(5, 8'hE0, 1'b0);
        chk("t6_busy_pre", bus.busy, 1);
        bus.in_valid = 1'b1; bus.in_byte = 8'hE5;
        reset = 1'b0;
        tick();
        chk("t6_rdy",    bus.in_ready, 0);
        chk("t6_wren",   bus.programWrEn, 0);
        chk("t6_addr",   bus.programAddress, 0);
        chk("t6_byte",   bus.programByte, 0);
        chk("t6_cpurst", bus.cpu_reset, 1);
        chk("t6_start",  bus.startProgram, 0);
        chk("t6_busy",   bus.busy, 0);
        chk("t6_done",   bus.done, 0);
        reset = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        tick();
        chk("t6_rdy_idle", bus.in_ready, 0);
        chk("t6_nwr", log0.size(), 5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
